// File: rtl/stopwatch_pkg.sv
// Shared encodings for the stopwatch control sequencer.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_PAUSED = 2'd1,
    ST_ADJUST = 2'd2
  } state_t;

  localparam logic FIELD_SEC = 1'b0;
  localparam logic FIELD_MIN = 1'b1;

endpackage

// File: rtl/stopwatch_ctrl_if.sv
// Control bundle from the sequencer to the mod-60 min/sec counter and display.
interface stopwatch_ctrl_if;
  logic       count_en;
  logic       adj_en;
  logic       adj_sel;
  logic       counter_clr;
  logic       paused;
  logic       blink;
  logic [1:0] state;

  modport master (output count_en, adj_en, adj_sel, counter_clr, paused, blink, state);
  modport slave  (input  count_en, adj_en, adj_sel, counter_clr, paused, blink, state);
endinterface

// File: rtl/button_debounce.sv
// Level debouncer for an already-synchronised button; emits one press pulse per
// accepted 0->1 transition, together with the level change.
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic level,
  output logic press
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);

  logic [CW-1:0] cnt;

  // Count consecutive samples that disagree with the accepted level.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt   <= '0;
      level <= 1'b0;
      press <= 1'b0;
    end else begin
      press <= 1'b0;
      if (btn_in == level) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        level <= btn_in;
        press <= btn_in;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end
endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control sequencer: prescaler (1 Hz / 2 Hz / blink), input
// synchronisers, button debouncers and RUN/PAUSED/ADJUST FSM.
// Optional lap-hold feature enabled by defining STOPWATCH_LAP_EN.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int CLK_HZ          = 100000000,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_pause,
  input  logic btn_reset,
  input  logic sw_select,
  input  logic sw_adjust,
`ifdef STOPWATCH_LAP_EN
  input  logic btn_lap,
  output logic lap_hold,
`endif
  stopwatch_ctrl_if.master bus
);
  localparam int Q  = CLK_HZ / 4;
  localparam int QW = $clog2(Q);
`ifdef STOPWATCH_LAP_EN
  localparam int NUM_BTN = 3;
`else
  localparam int NUM_BTN = 2;
`endif

  logic [NUM_BTN-1:0] raw_btn, lvl, prs;
  logic [NUM_BTN+1:0] meta, syn;
  logic               s_select, s_adjust, pause_press, rst_press;
  logic               running, q, tick1, tick2;

  state_t        state_q, state_nx;
  logic          paused_q, paused_nx;
  logic [QW-1:0] pre_q, pre_nx;
  logic [1:0]    phase_q, phase_nx;
  logic          cnt_q, cnt_nx, adj_q, adj_nx, clr_q, clr_nx;
`ifdef STOPWATCH_LAP_EN
  logic          lap_q, lap_nx, lap_press;
  assign raw_btn   = {btn_lap, btn_reset, btn_pause};
  assign lap_press = prs[2];
  assign lap_hold  = lap_q;
`else
  assign raw_btn   = {btn_reset, btn_pause};
`endif

  // Two-flop synchronisers for every raw input.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta <= '0;
      syn  <= '0;
    end else begin
      meta <= {sw_adjust, sw_select, raw_btn};
      syn  <= meta;
    end
  end

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_db
    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk    (clk),
      .rst    (rst),
      .btn_in (syn[i]),
      .level  (lvl[i]),
      .press  (prs[i])
    );
  end

  // Debounced levels are not needed here; only the press pulses drive the FSM.
  logic unused_lvl;
  assign unused_lvl = ^lvl;

  assign pause_press = prs[0];
  assign rst_press   = prs[1];
  assign s_select    = syn[NUM_BTN];
  assign s_adjust    = syn[NUM_BTN+1];

  // Quarter tick; the prescaler is frozen while paused so resume keeps position.
  assign running = (state_q != ST_PAUSED);
  assign q       = running && (pre_q == QW'(Q - 1));
  assign tick2   = q && phase_q[0];
  assign tick1   = q && (phase_q == 2'd3);

  // Next-state, prescaler and pulse decode; ticks use the pre-transition state.
  always_comb begin
    state_nx  = state_q;
    paused_nx = paused_q;
    pre_nx    = pre_q;
    phase_nx  = phase_q;
    cnt_nx    = 1'b0;
    adj_nx    = 1'b0;
    clr_nx    = 1'b0;
`ifdef STOPWATCH_LAP_EN
    lap_nx    = lap_q;
`endif
    if (running) begin
      pre_nx = q ? '0 : pre_q + QW'(1);
      if (q) phase_nx = phase_q + 2'd1;
    end
    if (rst_press) begin
      // Reset press wins over pause and suppresses any coincident tick.
      clr_nx    = 1'b1;
      pre_nx    = '0;
      phase_nx  = '0;
      paused_nx = 1'b0;
      state_nx  = s_adjust ? ST_ADJUST : ST_RUN;
    end else begin
      case (state_q)
        ST_RUN: begin
          cnt_nx = tick1;
          if (pause_press) begin
            state_nx  = ST_PAUSED;
            paused_nx = 1'b1;
          end else if (s_adjust) begin
            state_nx = ST_ADJUST;
          end
`ifdef STOPWATCH_LAP_EN
          if (lap_press) lap_nx = ~lap_q;
`endif
        end
        ST_PAUSED: begin
          if (pause_press) begin
            state_nx  = ST_RUN;
            paused_nx = 1'b0;
          end else if (s_adjust) begin
            state_nx = ST_ADJUST;
          end
        end
        ST_ADJUST: begin
          adj_nx = tick2;
          if (pause_press) paused_nx = ~paused_q;
          if (!s_adjust) state_nx = paused_nx ? ST_PAUSED : ST_RUN;
        end
        default: state_nx = ST_RUN;
      endcase
    end
`ifdef STOPWATCH_LAP_EN
    if (rst_press || state_nx != ST_RUN) lap_nx = 1'b0;
`endif
  end

  // State, prescaler and registered pulse outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_RUN;
      paused_q <= 1'b0;
      pre_q    <= '0;
      phase_q  <= '0;
      cnt_q    <= 1'b0;
      adj_q    <= 1'b0;
      clr_q    <= 1'b0;
`ifdef STOPWATCH_LAP_EN
      lap_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_nx;
      paused_q <= paused_nx;
      pre_q    <= pre_nx;
      phase_q  <= phase_nx;
      cnt_q    <= cnt_nx;
      adj_q    <= adj_nx;
      clr_q    <= clr_nx;
`ifdef STOPWATCH_LAP_EN
      lap_q    <= lap_nx;
`endif
    end
  end

  assign bus.count_en    = cnt_q;
  assign bus.adj_en      = adj_q;
  assign bus.counter_clr = clr_q;
  assign bus.paused      = paused_q;
  assign bus.state       = state_q;
  assign bus.adj_sel     = s_select;
  assign bus.blink       = (state_q == ST_ADJUST) && phase_q[1];
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Scoreboard bench for stopwatch_ctrl at CLK_HZ = 8, DEBOUNCE_CYCLES = 4.
// Expected events carry the absolute cycle (cyc) at which the registered output
// is visible; cyc restarts at 0 whenever rst is released.
module tb_stopwatch_ctrl;
  logic clk, rst, btn_pause, btn_reset, sw_select, sw_adjust;
`ifdef STOPWATCH_LAP_EN
  logic btn_lap, lap_hold;
`endif
  stopwatch_ctrl_if bus ();

  stopwatch_ctrl #(.CLK_HZ(8), .DEBOUNCE_CYCLES(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_pause (btn_pause),
    .btn_reset (btn_reset),
    .sw_select (sw_select),
    .sw_adjust (sw_adjust),
`ifdef STOPWATCH_LAP_EN
    .btn_lap   (btn_lap),
    .lap_hold  (lap_hold),
`endif
    .bus       (bus)
  );

  typedef struct {
    int         cyc;
    logic [2:0] sp;   // {state, paused}
  } st_exp_t;

  int      q_cnt[$], q_adj[$], q_clr[$];
  st_exp_t q_st[$];
  int      cyc;
  int      nchk = 0, npass = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or negedge rst)
    if (!rst) cyc <= 0;
    else      cyc <= cyc + 1;

  task automatic chk(input bit ok, input string nm, input int act, input int exp);
    nchk++;
    if (ok) npass++;
    else $display("FAIL %s: actual %0d required %0d (cyc %0d)", nm, act, exp, cyc);
  endtask

  task automatic pop_chk(input int k, input string nm);
    int e;
    e = -1;
    case (k)
      0: if (q_cnt.size() != 0) e = q_cnt.pop_front();
      1: if (q_adj.size() != 0) e = q_adj.pop_front();
      default: if (q_clr.size() != 0) e = q_clr.pop_front();
    endcase
    chk(e == cyc, nm, cyc, e);
  endtask

  task automatic push_st(input int c, input logic [1:0] s, input logic p);
    st_exp_t x;
    x.cyc = c;
    x.sp  = {s, p};
    q_st.push_back(x);
  endtask

  task automatic at_cyc(input int x);
    int n;
    n = 0;
    while (cyc != x && n < 1000) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (cyc != x) chk(1'b0, "at_cyc_timeout", cyc, x);
  endtask

  // Monitor: every pulse or {state,paused} change pops its expected event.
  initial begin : mon
    logic [2:0] prev, cur;
    st_exp_t    s;
    prev = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        prev = '0;
      end else begin
        if (bus.counter_clr) pop_chk(2, "counter_clr_cyc");
        if (bus.count_en)    pop_chk(0, "count_en_cyc");
        if (bus.adj_en)      pop_chk(1, "adj_en_cyc");
        if (bus.count_en || bus.adj_en)
          chk(!(bus.count_en && bus.adj_en), "cnt_adj_exclusive",
              int'(bus.count_en && bus.adj_en), 0);
        cur = {bus.state, bus.paused};
        if (cur != prev) begin
          if (q_st.size() != 0) s = q_st.pop_front();
          else begin s.cyc = -1; s.sp = 3'b111; end
          chk(s.cyc == cyc, "state_evt_cyc", cyc, s.cyc);
          chk(s.sp == cur, "state_evt_val", int'(cur), int'(s.sp));
          prev = cur;
        end
      end
    end
  end

  initial begin
    rst = 1'b0; btn_pause = 1'b0; btn_reset = 1'b0; sw_select = 1'b0; sw_adjust = 1'b0;
`ifdef STOPWATCH_LAP_EN
    btn_lap = 1'b0;
`endif
    #12;
    chk(bus.count_en == 1'b0,    "rst_count_en",    int'(bus.count_en), 0);
    chk(bus.adj_en == 1'b0,      "rst_adj_en",      int'(bus.adj_en), 0);
    chk(bus.counter_clr == 1'b0, "rst_counter_clr", int'(bus.counter_clr), 0);
    chk(bus.state == 2'd0,       "rst_state",       int'(bus.state), 0);
    chk(bus.paused == 1'b0,      "rst_paused",      int'(bus.paused), 0);
    chk(bus.blink == 1'b0,       "rst_blink",       int'(bus.blink), 0);

    // Free run: count_en every 8 cycles.
    for (int c = 8; c <= 32; c += 8) q_cnt.push_back(c);
    @(negedge clk);
    rst = 1'b1;
    at_cyc(20);
    chk(bus.blink == 1'b0, "run_blink", int'(bus.blink), 0);
    chk(bus.state == 2'd0, "run_state", int'(bus.state), 0);

    // Pause held 20 cycles: one transition; prescaler frozen at sub-phase 1.
    at_cyc(26); btn_pause = 1'b1; push_st(33, 2'd1, 1'b1);
    at_cyc(46); btn_pause = 1'b0;
    at_cyc(50);
    chk(bus.state == 2'd1, "paused_state", int'(bus.state), 1);
    chk(bus.paused == 1'b1, "paused_flag", int'(bus.paused), 1);
    // Resume at 63; remaining distance is 7 cycles, not 8.
    at_cyc(56); btn_pause = 1'b1; push_st(63, 2'd0, 1'b0);
    for (int c = 70; c <= 94; c += 8) q_cnt.push_back(c);
    at_cyc(66); btn_pause = 1'b0;

    // 3-cycle bounce: ignored.
    at_cyc(80); btn_pause = 1'b1;
    at_cyc(83); btn_pause = 1'b0;

    // Adjust mode, minutes field.
    at_cyc(96); sw_select = 1'b1;
    at_cyc(98); sw_adjust = 1'b1; push_st(101, 2'd2, 1'b0);
    for (int c = 102; c <= 126; c += 4) q_adj.push_back(c);
    at_cyc(104);
    chk(bus.adj_sel == 1'b1, "adj_sel", int'(bus.adj_sel), 1);
    chk(bus.blink == 1'b0, "blink_104", int'(bus.blink), 0);
    at_cyc(107);
    chk(bus.blink == 1'b1, "blink_107", int'(bus.blink), 1);
    at_cyc(110); btn_pause = 1'b1; push_st(117, 2'd2, 1'b1);
    at_cyc(111);
    chk(bus.blink == 1'b0, "blink_111", int'(bus.blink), 0);
    at_cyc(118); btn_pause = 1'b0;
    at_cyc(126); sw_adjust = 1'b0; sw_select = 1'b0; push_st(129, 2'd1, 1'b1);

    // Reset and pause pressed together while paused.
    at_cyc(136); btn_pause = 1'b1; btn_reset = 1'b1;
    q_clr.push_back(143); push_st(143, 2'd0, 1'b0); q_cnt.push_back(151);
    at_cyc(148); btn_pause = 1'b0; btn_reset = 1'b0; sw_select = 1'b1;
    at_cyc(152);
    chk(bus.adj_sel == 1'b1, "adj_sel_pre_rst", int'(bus.adj_sel), 1);

    // Asynchronous reset at phase 2.
    at_cyc(156);
    #2 rst = 1'b0;
    #1;
    chk(bus.adj_sel == 1'b0,     "arst_adj_sel",  int'(bus.adj_sel), 0);
    chk(bus.state == 2'd0,       "arst_state",    int'(bus.state), 0);
    chk(bus.count_en == 1'b0,    "arst_count_en", int'(bus.count_en), 0);
    chk(bus.adj_en == 1'b0,      "arst_adj_en",   int'(bus.adj_en), 0);
    chk(bus.counter_clr == 1'b0, "arst_clr",      int'(bus.counter_clr), 0);
    chk(bus.blink == 1'b0,       "arst_blink",    int'(bus.blink), 0);
    q_cnt.push_back(8); q_cnt.push_back(16);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    at_cyc(20);

    while (q_cnt.size() != 0) chk(1'b0, "missing_count_en", -1, q_cnt.pop_front());
    while (q_adj.size() != 0) chk(1'b0, "missing_adj_en", -1, q_adj.pop_front());
    while (q_clr.size() != 0) chk(1'b0, "missing_counter_clr", -1, q_clr.pop_front());
    while (q_st.size() != 0) begin
      st_exp_t s;
      s = q_st.pop_front();
      chk(1'b0, "missing_state_evt", -1, s.cyc);
    end

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end
endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
Control sequencer for the stopwatch mod-60 minutes/seconds counter. Runs entirely in the board clock domain. Derives 1 Hz count, 2 Hz adjust and blink enables from one prescaler. Debounces the pause/reset buttons, synchronises the select/adjust switches and runs the RUN/PAUSED/ADJUST state machine that tells the counter when to advance and which field.

Parameters:
CLK_HZ, 100000000, board clock frequency; must be a multiple of 4 and at least 8
DEBOUNCE_CYCLES, 1000000, consecutive stable synchronised samples before a button level is accepted; at least 2

Ports:
clk  input  1  board clock; all logic on rising edge
rst  input  1  asynchronous, active-low reset
btn_pause  input  1  raw pause button, active-high, asynchronous
btn_reset  input  1  raw reset button, active-high, asynchronous
sw_select  input  1  raw switch: 0 = seconds field, 1 = minutes field
sw_adjust  input  1  raw switch: 1 = adjust mode
count_en  output  1  one-cycle pulse: counter advances seconds by one (1 Hz, RUN only)
adj_en  output  1  one-cycle pulse: counter advances selected field by one (2 Hz, ADJUST only)
adj_sel  output  1  synchronised sw_select
counter_clr  output  1  one-cycle pulse: counter clears to 00:00
paused  output  1  pause flag
blink  output  1  display blink phase for selected field; 0 outside ADJUST
state  output  2  0 = RUN, 1 = PAUSED, 2 = ADJUST

Behaviour:
- Reset (rst low, asynchronous): state = RUN; paused = 0; blink = 0; all pulses = 0; prescaler = 0; phase = 0; synchronisers and debouncers = 0.
- Synchronisers: all four raw inputs pass through 2-FF synchronisers.
- Switches: used directly after synchronisation (2-cycle latency).
- Buttons: go through button_debounce.
  - Debounced level changes only after DEBOUNCE_CYCLES consecutive equal synchronised samples.
  - A 0->1 debounced transition gives a one-cycle press pulse in the same cycle.
  - Holding a button produces exactly one pulse.
- Prescaler:
  - Counter 0..CLK_HZ/4-1; each wrap gives a quarter tick q and increments a 2-bit phase.
  - 2 Hz tick = q with phase[0] = 1. 1 Hz tick = q with phase = 3.
  - blink = phase[1] while in ADJUST.
  - Prescaler and phase hold while state = PAUSED, so resume keeps the sub-second position.
- FSM:
  - RUN: count_en = 1 Hz tick.
    - pause press -> PAUSED, paused = 1.
    - sw_adjust = 1 -> ADJUST.
  - PAUSED: no pulses.
    - pause press -> RUN, paused = 0.
    - sw_adjust = 1 -> ADJUST.
  - ADJUST: adj_en = 2 Hz tick; count_en = 0.
    - pause press toggles the paused flag only.
    - sw_adjust = 0 -> PAUSED if paused = 1, else RUN.
- Reset press:
  - Any state: counter_clr = 1 for exactly one cycle.
  - Prescaler and phase cleared; paused cleared.
  - State -> RUN, or ADJUST if sw_adjust = 1.
  - Reset press has priority over a simultaneous pause press, which is discarded.
- Simultaneous events:
  - A tick in the same cycle as reset press is suppressed.
  - A tick in the same cycle as a transition is governed by the pre-transition state (registered outputs).
  - count_en and adj_en are never high together.
- Pulse latency: all pulses are registered, one cycle after the causing tick or press.

Optional Feature:
STOPWATCH_LAP_EN: adds input btn_lap (debounced like the other buttons) and output lap_hold.
- With the macro: in RUN, each lap press toggles lap_hold. While lap_hold = 1 the display freezes, but counting continues. Leaving RUN or a reset press clears lap_hold.
- Without the macro: neither port exists, and behaviour is otherwise identical.

Decomposition:
- Package stopwatch_pkg holds:
  - state encodings ST_RUN = 2'd0, ST_PAUSED = 2'd1, ST_ADJUST = 2'd2
  - FIELD_SEC = 1'b0, FIELD_MIN = 1'b1
- Sub-module button_debounce (parameter DEBOUNCE_CYCLES; ports clk, rst, btn_in, level, press), instantiated per button.
- Prescaler and FSM stay in stopwatch_ctrl.

Test Plan:
All scenarios use CLK_HZ = 8, DEBOUNCE_CYCLES = 4.
- Release rst, sw_adjust = 0 -> count_en pulses exactly every 8 cycles; adj_en, counter_clr and blink stay 0; state = 0.
- Pause held 20 cycles in RUN, then a second press -> state goes 1 then back to 0 with one transition each. During the pause no count_en. The first count_en after resume arrives at the remaining prescaler distance, not a full 8.
- Pause pulse 3 cycles long (bounce) -> no state change.
- Raise sw_adjust with sw_select = 1 -> after sync, state = 2; adj_en every 4 cycles; adj_sel = 1; blink toggles every 4 cycles. Lower sw_adjust -> returns to RUN, or to PAUSED if a pause was pressed in ADJUST.
- Reset press and pause press debounced in the same cycle while paused -> one counter_clr pulse; state = 0, paused = 0. The next count_en arrives 8 cycles later.
- Assert rst mid-count with phase = 2 -> all outputs 0 immediately (asynchronous), and prescaler restarts from 0 after release.
